// File: rtl/ysyx_24110015_lsu_pkg.sv
// ysyx_24110015_lsu_pkg: FSM state encoding and RV32 load/store func3 codes shared by the LSU.
package ysyx_24110015_lsu_pkg;
   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
   typedef enum logic [2:0] {F3_SB = 3'b000, F3_SH = 3'b001, F3_SW = 3'b010} store_f3_t;
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
endpackage

// File: rtl/ysyx_24110015_LoadExt.sv
// ysyx_24110015_LoadExt: sign/zero extension of load data selected by func3; unknown codes give 0.
module ysyx_24110015_LoadExt
   import ysyx_24110015_lsu_pkg::*;
(
   input  logic [2:0]  func3,
   input  logic [31:0] data,
   output logic [31:0] result
);
   always_comb
      result = func3 == F3_LB  ? {{24{data[7]}}, data[7:0]}
             : func3 == F3_LH  ? {{16{data[15]}}, data[15:0]}
             : func3 == F3_LW  ? data
             : func3 == F3_LBU ? {24'd0, data[7:0]}
             : func3 == F3_LHU ? {16'd0, data[15:0]}
             : '0;
endmodule

// File: rtl/ysyx_24110015_lsu.sv
// ysyx_24110015_lsu: load/store unit between execute and write-back with a valid/ready memory bus and response timeout.
// Define YSYX_24110015_LSU_ALIGN_EN to shift store data/strobes and load data by the address byte offset.
module ysyx_24110015_lsu
   import ysyx_24110015_lsu_pkg::*;
#(
   parameter int TIMEOUT_CYC = 1023
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        processing,
   input  logic [31:0] alu_out_i,
   input  logic [31:0] mem_wdata_i,
   input  logic [3:0]  mem_wmask_i,
   input  logic [2:0]  func3_i,
   input  logic        MemRead_i,
   input  logic        MemWrite_i,
   input  logic [31:0] pc_i,
   input  logic [31:0] inst_i,
   input  logic        RegWrite_i,
   input  logic [4:0]  wb_addr_i,
   input  logic        zicsr_i,
   input  logic [31:0] csr_rdata_i,
   input  logic        ebreak_i,
   output logic [31:0] pc_o,
   output logic [31:0] inst_o,
   output logic        RegWrite_o,
   output logic [4:0]  wb_addr_o,
   output logic        zicsr_o,
   output logic [31:0] csr_rdata_o,
   output logic        ebreak_o,
   output logic [31:0] wb_data_o,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [31:0] mem_addr,
   output logic        mem_wen,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic        mem_resp_valid,
   input  logic [31:0] mem_rdata,
   output logic        access_fault
);
   localparam int CW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

   state_t        state, state_nx;
   logic [31:0]   alu_q, wdata_q, rdata_q, load_raw, load_ext;
   logic [3:0]    wmask_q;
   logic [2:0]    func3_q;
   logic          read_q, write_q, accept, timeout;
   logic [CW-1:0] cnt;

   assign accept     = in_valid & in_ready;
   assign timeout    = (state == WAIT) && !mem_resp_valid && (cnt == LAST);
   assign processing = accept | (state != IDLE);

   always_ff @(posedge clk)
      state <= !rst ? IDLE : state_nx;

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (accept) state_nx = (MemRead_i | MemWrite_i) ? REQ : DONE;
         REQ:     if (mem_req_ready) state_nx = WAIT;
         WAIT:    if (mem_resp_valid | timeout) state_nx = DONE;
         DONE:    if (out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      in_ready      = state == IDLE;
      out_valid     = state == DONE;
      mem_req_valid = state == REQ;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         alu_q        <= '0;
         wdata_q      <= '0;
         wmask_q      <= '0;
         func3_q      <= '0;
         read_q       <= 1'b0;
         write_q      <= 1'b0;
         rdata_q      <= '0;
         cnt          <= '0;
         access_fault <= 1'b0;
         pc_o         <= '0;
         inst_o       <= '0;
         RegWrite_o   <= 1'b0;
         wb_addr_o    <= '0;
         zicsr_o      <= 1'b0;
         csr_rdata_o  <= '0;
         ebreak_o     <= 1'b0;
      end else begin
         access_fault <= timeout;
         if (accept) begin
            alu_q       <= alu_out_i;
            wdata_q     <= mem_wdata_i;
            wmask_q     <= mem_wmask_i;
            func3_q     <= func3_i;
            read_q      <= MemRead_i;
            write_q     <= MemWrite_i;
            pc_o        <= pc_i;
            inst_o      <= inst_i;
            RegWrite_o  <= RegWrite_i;
            wb_addr_o   <= wb_addr_i;
            zicsr_o     <= zicsr_i;
            csr_rdata_o <= csr_rdata_i;
            ebreak_o    <= ebreak_i;
         end
         if (state == REQ && mem_req_ready)
            cnt <= '0;
         else if (state == WAIT)
            cnt <= cnt + 1'b1;
         // a timed-out access returns zero data
         if (state == WAIT && (mem_resp_valid | timeout))
            rdata_q <= mem_resp_valid ? mem_rdata : '0;
      end
   end

   assign mem_addr = alu_q;
   assign mem_wen  = write_q;
`ifdef YSYX_24110015_LSU_ALIGN_EN
   assign mem_wstrb = wmask_q << alu_q[1:0];
   assign mem_wdata = wdata_q << {alu_q[1:0], 3'b000};
   assign load_raw  = rdata_q >> {alu_q[1:0], 3'b000};
`else
   assign mem_wstrb = wmask_q;
   assign mem_wdata = wdata_q;
   assign load_raw  = rdata_q;
`endif

   ysyx_24110015_LoadExt u_ext (
      .func3  (func3_q),
      .data   (load_raw),
      .result (load_ext)
   );

   assign wb_data_o = read_q ? load_ext : alu_q;
endmodule

// File: tb/tb_ysyx_24110015_lsu.sv
// tb_ysyx_24110015_lsu: randomized scoreboard bench for the LSU with a behavioural memory responder.
module tb_ysyx_24110015_lsu;
`ifdef YSYX_24110015_LSU_ALIGN_EN
   localparam bit ALIGN = 1'b1;
`else
   localparam bit ALIGN = 1'b0;
`endif
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic in_valid, in_ready, out_valid, out_ready, processing;
   logic [31:0] alu_out_i, mem_wdata_i, pc_i, inst_i, csr_rdata_i;
   logic [3:0]  mem_wmask_i;
   logic [2:0]  func3_i;
   logic        MemRead_i, MemWrite_i, RegWrite_i, zicsr_i, ebreak_i;
   logic [4:0]  wb_addr_i;
   logic [31:0] pc_o, inst_o, csr_rdata_o, wb_data_o, mem_addr, mem_wdata, mem_rdata;
   logic        RegWrite_o, zicsr_o, ebreak_o, mem_req_valid, mem_req_ready, mem_wen;
   logic        mem_resp_valid, access_fault;
   logic [4:0]  wb_addr_o;
   logic [3:0]  mem_wstrb;

   always #5 clk = ~clk;

   ysyx_24110015_lsu #(.TIMEOUT_CYC(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .out_valid(out_valid), .out_ready(out_ready), .processing(processing),
      .alu_out_i(alu_out_i), .mem_wdata_i(mem_wdata_i), .mem_wmask_i(mem_wmask_i),
      .func3_i(func3_i), .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
      .pc_i(pc_i), .inst_i(inst_i), .RegWrite_i(RegWrite_i), .wb_addr_i(wb_addr_i),
      .zicsr_i(zicsr_i), .csr_rdata_i(csr_rdata_i), .ebreak_i(ebreak_i),
      .pc_o(pc_o), .inst_o(inst_o), .RegWrite_o(RegWrite_o), .wb_addr_o(wb_addr_o),
      .zicsr_o(zicsr_o), .csr_rdata_o(csr_rdata_o), .ebreak_o(ebreak_o),
      .wb_data_o(wb_data_o), .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
      .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata), .access_fault(access_fault)
   );

   typedef struct { logic [31:0] wb, pc, inst, csr; logic [4:0] wba; logic rw, zicsr, ebreak; int fault; } exp_t;
   typedef struct { logic [31:0] addr, wdata; logic [3:0] wstrb; logic wen; } req_t;
   typedef struct { logic [31:0] rdata; int delay; bit tmo; } rsp_t;
   exp_t sb[$];
   req_t rq[$];
   rsp_t rs[$];

   int checks = 0;
   int passed = 0;
   bit force_resp = 1'b0;
   int bp = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h, want %h", name, act, exp);
   endtask

   task automatic fail(input string name);
      checks++;
      $display("FAIL %s: condition not reached", name);
   endtask

   // reference load: byte offset shift, then sign/zero extension by plain arithmetic
   function automatic logic [31:0] load_model(input logic [31:0] raw, input logic [31:0] addr, input logic [2:0] f3);
      logic [31:0] d, b, h;
      d = ALIGN ? raw >> (8 * int'(addr % 32'd4)) : raw;
      b = d % 32'h100;
      h = d % 32'h10000;
      case (f3)
         3'd0:    return b >= 32'h80 ? b - 32'h100 : b;
         3'd1:    return h >= 32'h8000 ? h - 32'h10000 : h;
         3'd2:    return d;
         3'd4:    return b;
         3'd5:    return h;
         default: return 32'd0;
      endcase
   endfunction

   task automatic issue(input logic [31:0] alu, input logic [31:0] wd, input logic [3:0] wm,
                        input logic [2:0] f3, input logic rd, input logic wr, input logic [31:0] rdata,
                        input int dly, input bit tmo, input bit rec);
      exp_t e;
      req_t r;
      rsp_t p;
      bit acc;
      int n;
      @(posedge clk); #1;
      alu_out_i = alu; mem_wdata_i = wd; mem_wmask_i = wm; func3_i = f3;
      MemRead_i = rd; MemWrite_i = wr;
      pc_i = $urandom; inst_i = $urandom; csr_rdata_i = $urandom;
      wb_addr_i = 5'($urandom); RegWrite_i = 1'($urandom); zicsr_i = 1'($urandom); ebreak_i = 1'($urandom);
      e.wb = !rd ? alu : tmo ? 32'd0 : load_model(rdata, alu, f3);
      e.pc = pc_i; e.inst = inst_i; e.csr = csr_rdata_i; e.wba = wb_addr_i;
      e.rw = RegWrite_i; e.zicsr = zicsr_i; e.ebreak = ebreak_i;
      e.fault = ((rd | wr) && tmo) ? 1 : 0;
      if (rec) sb.push_back(e);
      if (rd | wr) begin
         r.addr = alu; r.wen = wr;
         r.wdata = ALIGN ? wd << (8 * int'(alu % 32'd4)) : wd;
         r.wstrb = ALIGN ? 4'(wm << (alu % 32'd4)) : wm;
         rq.push_back(r);
         p.rdata = rdata; p.delay = dly; p.tmo = tmo;
         rs.push_back(p);
      end
      in_valid = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         acc = in_ready;
         if (acc) chk("processing_on_accept", processing, 1);
         @(posedge clk); #1;
         n++;
      end while (!acc && n < 300);
      in_valid = 1'b0;
      if (!acc) fail("accept");
      else if (!(rd | wr)) begin
         @(negedge clk);
         chk("nonmem_out_valid_next_cycle", out_valid, 1);
         chk("nonmem_no_mem_req", mem_req_valid, 0);
      end
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      do begin @(negedge clk); n++; end while ((sb.size() != 0 || !in_ready) && n < 500);
      if (sb.size() != 0 || !in_ready) fail("drain");
   endtask

   initial begin : responder
      bit hs;
      bit rv_prev;
      int dly;
      rsp_t cur;
      rv_prev = 1'b0; dly = -1;
      cur.rdata = '0; cur.delay = 0; cur.tmo = 1'b0;
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0;
      forever begin
         @(posedge clk); #1;
         hs = rv_prev && mem_req_ready;
         mem_resp_valid = 1'b0;
         if (hs) begin
            if (rs.size() == 0) dly = -1;
            else begin cur = rs.pop_front(); dly = cur.tmo ? -1 : cur.delay; end
         end else if (dly > 0) dly--;
         if (dly == 0) begin
            mem_resp_valid = 1'b1; mem_rdata = cur.rdata; dly = -1;
         end else if (force_resp || (dly < 0 && (in_ready || out_valid || mem_req_valid) && $urandom_range(0, 3) == 0)) begin
            // stray response while the LSU is not waiting; must be ignored
            mem_resp_valid = 1'b1; mem_rdata = $urandom;
         end
         mem_req_ready = $urandom_range(0, 2) == 0;
         rv_prev = mem_req_valid;
      end
   end

   initial begin : sink
      out_ready = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (bp > 0 && out_valid) begin out_ready = 1'b0; bp--; end
         else out_ready = $urandom_range(0, 3) != 0;
      end
   end

   initial begin : req_mon
      forever begin
         @(negedge clk);
         if (rst && mem_req_valid) begin
            if (rq.size() == 0) fail("unexpected_mem_req");
            else begin
               chk("mem_addr", mem_addr, rq[0].addr);
               chk("mem_wen", mem_wen, rq[0].wen);
               chk("mem_wdata", mem_wdata, rq[0].wdata);
               chk("mem_wstrb", mem_wstrb, rq[0].wstrb);
               if (mem_req_ready) void'(rq.pop_front());
            end
         end
      end
   end

   initial begin : out_mon
      exp_t e;
      int faults;
      bit stall;
      logic [31:0] prev_wb, prev_pc;
      faults = 0; stall = 1'b0; prev_wb = '0; prev_pc = '0;
      forever begin
         @(negedge clk);
         if (access_fault) faults++;
         if (out_valid) begin
            chk("in_ready_low_in_done", in_ready, 0);
            if (stall) begin
               chk("stall_wb_stable", wb_data_o, prev_wb);
               chk("stall_pc_stable", pc_o, prev_pc);
            end
            if (out_ready) begin
               if (sb.size() == 0) fail("unexpected_out_valid");
               else begin
                  e = sb.pop_front();
                  chk("wb_data_o", wb_data_o, e.wb);
                  chk("pc_o", pc_o, e.pc);
                  chk("inst_o", inst_o, e.inst);
                  chk("csr_rdata_o", csr_rdata_o, e.csr);
                  chk("wb_addr_o", wb_addr_o, e.wba);
                  chk("RegWrite_o", RegWrite_o, e.rw);
                  chk("zicsr_o", zicsr_o, e.zicsr);
                  chk("ebreak_o", ebreak_o, e.ebreak);
                  chk("access_fault_pulses", faults, e.fault);
               end
               faults = 0; stall = 1'b0;
            end else begin
               stall = 1'b1; prev_wb = wb_data_o; prev_pc = pc_o;
            end
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int k, n;
      bit seen;
      in_valid = 1'b0; alu_out_i = '0; mem_wdata_i = '0; mem_wmask_i = '0; func3_i = '0;
      MemRead_i = 1'b0; MemWrite_i = 1'b0; pc_i = '0; inst_i = '0; csr_rdata_i = '0;
      RegWrite_i = 1'b0; wb_addr_i = '0; zicsr_i = 1'b0; ebreak_i = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_mem_req_valid", mem_req_valid, 0);
      chk("rst_access_fault", access_fault, 0);
      chk("rst_processing", processing, 0);
      chk("rst_wb_data_o", wb_data_o, 0);
      chk("rst_pc_o", pc_o, 0);
      chk("rst_csr_rdata_o", csr_rdata_o, 0);
      @(posedge clk); #1;
      rst = 1'b1;

      issue(32'h0000_1234, 32'd0, 4'd0, 3'd0, 1'b0, 1'b0, 32'd0, 0, 1'b0, 1'b1);
      issue(32'h8000_0003, 32'd0, 4'd0, 3'b000, 1'b1, 1'b0, 32'h80FF_FFFF, 2, 1'b0, 1'b1);
      issue(32'h8000_0002, 32'h0000_ABCD, 4'b0011, 3'b001, 1'b0, 1'b1, 32'd0, 1, 1'b0, 1'b1);
      wait_idle();
      bp = 5;
      issue(32'h0BAD_F00D, 32'd0, 4'd0, 3'd0, 1'b0, 1'b0, 32'd0, 0, 1'b0, 1'b1);
      issue(32'h0000_0040, 32'd0, 4'd0, 3'b010, 1'b0, 1'b0, 32'd0, 0, 1'b0, 1'b1);
      issue(32'h8000_0010, 32'd0, 4'd0, 3'b010, 1'b1, 1'b0, 32'hDEAD_BEEF, 0, 1'b1, 1'b1);

      for (int i = 0; i < 150; i++) begin
         k = $urandom_range(0, 2);
         issue($urandom, $urandom, 4'($urandom), 3'($urandom_range(0, 7)), k == 1, k == 2,
               $urandom, $urandom_range(0, 5), $urandom_range(0, 7) == 0, 1'b1);
      end
      wait_idle();

      // reset while waiting for a response that never comes on time
      issue(32'h8000_0100, 32'd0, 4'd0, 3'b010, 1'b1, 1'b0, 32'h1234_5678, 0, 1'b1, 1'b0);
      n = 0; seen = 1'b0;
      do begin
         @(negedge clk);
         if (mem_req_valid) seen = 1'b1;
         n++;
      end while (!(seen && !mem_req_valid) && n < 100);
      if (!(seen && !mem_req_valid)) fail("reach_wait");
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      chk("wait_rst_in_ready", in_ready, 1);
      chk("wait_rst_processing", processing, 0);
      chk("wait_rst_pc_o", pc_o, 0);
      chk("wait_rst_wb_data_o", wb_data_o, 0);
      force_resp = 1'b1;
      @(negedge clk);
      force_resp = 1'b0;
      repeat (12) begin
         @(negedge clk);
         chk("late_resp_out_valid", out_valid, 0);
         chk("late_resp_access_fault", access_fault, 0);
      end
      issue(32'h0000_5678, 32'd0, 4'd0, 3'd0, 1'b0, 1'b0, 32'd0, 0, 1'b0, 1'b1);
      wait_idle();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
